// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   - uart_state_e : transmit FSM states
//   - ADDR_*       : byte offsets of the memory-mapped registers (addr[7:0])
//   - STAT_*       : bit positions inside the STATUS register
//   - CTRL_*       : bit positions inside the CTRL register
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [7:0] ADDR_TXDATA = 8'h00;
    localparam logic [7:0] ADDR_DIV    = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h0C;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 8;

    localparam int unsigned CTRL_PAR_EN  = 0;
    localparam int unsigned CTRL_PAR_ODD = 1;
    localparam int unsigned CTRL_STOP2   = 2;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write strobe and data (ignored while full)
//   i_pop            read strobe (ignored while empty)
//   o_dout           head entry, valid while !o_empty
//   o_full, o_empty  occupancy flags derived from the count register
//   o_count          number of stored entries (0..DEPTH)
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // count never exceeds DEPTH (a power of two), so its MSB alone means full
    assign o_full  = r_count[AW];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with TX FIFO, optional
// even/odd parity, 1 or 2 stop bits, sticky overflow flag and empty irq.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wen         1 = write cycle, 0 = read cycle
//   addr        byte address, addr[7:0] decoded (TXDATA/DIV/STATUS/CTRL)
//   wdata       write data
//   rdata       registered read data, unchanged on unmapped reads
//   tx          serial output, idles high
//   irq_empty   registered: FIFO empty and transmitter idle
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq_empty
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic [31:0]          r_div;
    logic [31:0]          r_cnt;
    logic [2:0]           r_ctrl;
    logic                 r_cfg_par_en;
    logic                 r_cfg_stop2;
    logic                 r_par;
    logic                 r_stop2nd;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit;
    logic                 r_ovf;
    logic                 r_tx;
    logic                 r_irq;
    logic [31:0]          r_rdata;

    logic [7:0]           w_addr;
    logic                 w_unused_addr;
    logic [DATA_BITS-1:0] w_fifo_dout;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_busy;
    logic [31:0]          w_status;

    assign w_addr        = addr[7:0];
    assign w_unused_addr = ^addr[31:8];

    assign tx        = r_tx;
    assign irq_empty = r_irq;
    assign rdata     = r_rdata;

    assign w_tick      = (r_cnt == '0);
    assign w_last_stop = !r_cfg_stop2 || r_stop2nd;
    assign w_push      = wen && (w_addr == ADDR_TXDATA) && !w_full;
    // Pop either from idle, or at the end of the final stop bit so the next
    // start bit follows with no idle gap.
    assign w_pop       = !w_empty &&
                         ((r_state == ST_IDLE) ||
                          (r_state == ST_STOP && w_tick && w_last_stop));
    assign w_busy      = !w_empty || (r_state != ST_IDLE);

    always_comb begin
        w_status                        = '0;
        w_status[STAT_BUSY]             = w_busy;
        w_status[STAT_FULL]             = w_full;
        w_status[STAT_EMPTY]            = w_empty;
        w_status[STAT_OVF]              = r_ovf;
        w_status[STAT_CNT_LSB +: 8]     = 8'(w_count);
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_din   (wdata[DATA_BITS-1:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Bus registers and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= DEFAULT_DIV;
            r_ctrl  <= '0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else if (wen) begin
            case (w_addr)
                ADDR_TXDATA: if (w_full) r_ovf <= 1'b1;
                ADDR_DIV:    r_div  <= wdata;
                ADDR_CTRL:   r_ctrl <= wdata[2:0];
                default:     ;
            endcase
        end else begin
            case (w_addr)
                ADDR_DIV:    r_rdata <= r_div;
                ADDR_STATUS: begin
                    r_rdata <= w_status;
                    r_ovf   <= 1'b0;
                end
                ADDR_CTRL:   r_rdata <= {29'd0, r_ctrl};
                default:     ;
            endcase
        end
    end

    // Baud counter: a bit lasts DIV+1 cycles, tick on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= DEFAULT_DIV;
        end else if (wen && (w_addr == ADDR_DIV)) begin
            r_cnt <= wdata;
        end else if (w_pop || w_tick) begin
            r_cnt <= r_div;
        end else begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    // Transmit FSM. tx is registered and changes together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tx         <= 1'b1;
            r_shift      <= '0;
            r_bit        <= '0;
            r_cfg_par_en <= 1'b0;
            r_cfg_stop2  <= 1'b0;
            r_par        <= 1'b0;
            r_stop2nd    <= 1'b0;
            r_irq        <= 1'b1;
        end else begin
            r_irq <= w_empty && (r_state == ST_IDLE);

            // Frame config and parity are captured with the data so that
            // CTRL writes only affect frames popped afterwards.
            if (w_pop) begin
                r_shift      <= w_fifo_dout;
                r_cfg_par_en <= r_ctrl[CTRL_PAR_EN];
                r_cfg_stop2  <= r_ctrl[CTRL_STOP2];
                r_par        <= (^w_fifo_dout) ^ r_ctrl[CTRL_PAR_ODD];
            end

            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state <= ST_START;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit == LAST_BIT) begin
                            r_stop2nd <= 1'b0;
                            if (r_cfg_par_en) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state   <= ST_STOP;
                        r_tx      <= 1'b1;
                        r_stop2nd <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (!w_last_stop) begin
                            r_stop2nd <= 1'b1;
                        end else if (w_pop) begin
                            r_state <= ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
